// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter for a shared N-input stream mux: locks one requester for a
// whole packet (first beat through last) and steers its data to the single output.
module mux_rr_arbiter #(
  parameter int SELECT_LINES = 2,
  parameter int DATA_WIDTH   = 8,
  localparam int N           = 2 ** SELECT_LINES
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N-1:0]            in_valid,
  input  logic [N-1:0]            in_last,
  input  logic [DATA_WIDTH*N-1:0] in_data,
  output logic [N-1:0]            in_ready,
  output logic                    out_valid,
  output logic                    out_last,
  output logic [DATA_WIDTH-1:0]   out_data,
  input  logic                    out_ready,
  output logic [SELECT_LINES-1:0] grant_sel,
  output logic                    busy
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                  state_reg;
  logic [SELECT_LINES-1:0] rr_ptr_reg;
  logic [SELECT_LINES-1:0] winner;
  logic [SELECT_LINES-1:0] cand;
  logic                    found;
  logic [DATA_WIDTH-1:0]   slices [N];

  assign busy = (state_reg == LOCKED);

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_req
      assign slices[gi]   = in_data[DATA_WIDTH*gi +: DATA_WIDTH];
      assign in_ready[gi] = busy & out_ready & (grant_sel == SELECT_LINES'(gi));
    end
  endgenerate

  assign out_data  = slices[grant_sel];
  assign out_valid = busy & in_valid[grant_sel];
  assign out_last  = busy & in_last[grant_sel];

  // Scan from rr_ptr upwards; the select-width add wraps N-1 back to 0 for free.
  always_comb begin
    found  = 1'b0;
    winner = rr_ptr_reg;
    cand   = rr_ptr_reg;
    for (int i = 0; i < N; i++) begin
      cand = rr_ptr_reg + SELECT_LINES'(i);
      if (!found && in_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      grant_sel  <= '0;
      rr_ptr_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (found) begin
            grant_sel <= winner;
            state_reg <= LOCKED;
          end
        end
        LOCKED: begin
          // Just-served requester drops to lowest priority for the next round.
          if (out_valid && out_ready && out_last) begin
            state_reg  <= IDLE;
            rr_ptr_reg <= grant_sel + SELECT_LINES'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
